// File: rtl/stream_merge_2x1_pkg.sv
// Shared definitions for the 2:1 packet merger: FSM state encodings and
// source index constants.
package stream_merge_2x1_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY0 = 2'd1,
      ST_BUSY1 = 2'd2
   } state_t;

   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;

   // Locked state for a packet that is still open on source idx.
   function automatic state_t busy_state(input logic idx);
      return (idx == SRC1) ? ST_BUSY1 : ST_BUSY0;
   endfunction

endpackage

// File: rtl/stream_merge_2x1_rr_grant_2.sv
// Combinational two-way round-robin grant with packet lock override.
module rr_grant_2
   import stream_merge_2x1_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   input  logic       lock,
   input  logic       lock_src,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   // A locked packet owns the output whether or not its source is valid.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = SRC0;
      if (lock) begin
         gnt_valid = 1'b1;
         gnt_idx   = lock_src;
      end else if (req == 2'b11) begin
         gnt_valid = 1'b1;
         gnt_idx   = prio;
      end else if (req[0]) begin
         gnt_valid = 1'b1;
         gnt_idx   = SRC0;
      end else if (req[1]) begin
         gnt_valid = 1'b1;
         gnt_idx   = SRC1;
      end
   end

endmodule

// File: rtl/stream_merge_2x1.sv
// Two-input packet merger: round-robin arbitration per packet, one-cycle
// registered output stage with source index.
module stream_merge_2x1
   import stream_merge_2x1_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_last,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_last,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_src,
   input  logic             out_ready
);

   state_t           state;
   logic             prio;
   logic             lock;
   logic             lock_src;
   logic             gnt_valid;
   logic             gnt_idx;
   logic             load_en;
   logic             sel_valid;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last;
   logic             accept;

   assign lock     = (state != ST_IDLE);
   assign lock_src = (state == ST_BUSY1) ? SRC1 : SRC0;

   rr_grant_2 u_grant (
      .req       ({in1_valid, in0_valid}),
      .prio      (prio),
      .lock      (lock),
      .lock_src  (lock_src),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign load_en   = !out_valid || out_ready;
   // Readies are held low during reset so no beat is lost upstream.
   assign in0_ready = !rst && load_en && gnt_valid && (gnt_idx == SRC0);
   assign in1_ready = !rst && load_en && gnt_valid && (gnt_idx == SRC1);

   assign sel_valid = (gnt_idx == SRC1) ? in1_valid : in0_valid;
   assign sel_data  = (gnt_idx == SRC1) ? in1_data  : in0_data;
   assign sel_last  = (gnt_idx == SRC1) ? in1_last  : in0_last;
   assign accept    = !rst && load_en && gnt_valid && sel_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         prio      <= SRC0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= SRC0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_last  <= sel_last;
         out_src   <= gnt_idx;
         if (sel_last) begin
            state <= ST_IDLE;
            prio  <= !gnt_idx;
         end else begin
            state <= busy_state(gnt_idx);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
